// File: rtl/pll_lock_sequencer.sv
// PLL lock qualification and downstream reset sequencing.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  PLLRST (0) | holding the PLL in reset for PLL_RST_CYCLES cycles
//  WAIT_LOCK(1)| PLL released, waiting for lock; re-resets PLL on timeout
//  STABILIZE(2)| lock seen, requiring STABLE_CYCLES unbroken lock cycles
//  HOLD (3)   | lock qualified, keeping sys_rst_n low HOLD_CYCLES more
//  RUN (4)    | downstream out of reset, symbol tick running
//
// All outputs are registered from next-state values, so each output
// reflects the state the FSM is in during that same cycle.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int TICK_DIV       = 16,
    parameter int CNT_W          = 17
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pll_locked,
    output logic                        pll_rst,
    output logic                        sys_rst_n,
    output logic                        ready,
    output logic                        tick,
    output logic [$clog2(TICK_DIV)-1:0] tick_phase,
    output logic [7:0]                  loss_count,
    output logic [2:0]                  state
);

    localparam int TP_W = $clog2(TICK_DIV);

    localparam logic [2:0] S_PLLRST    = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABILIZE = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    // Terminal-count values for the shared phase counter
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [TP_W-1:0]  TP_LAST      = TP_W'(TICK_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             next_state;
    logic [TP_W-1:0]        next_phase;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous PLL lock flag into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state decode; lock takes priority over the WAIT_LOCK timeout
    always_comb begin
        next_state = state;
        case (state)
            S_PLLRST: begin
                if (cnt == PLL_RST_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)                 next_state = S_STABILIZE;
                else if (cnt == TIMEOUT_LAST) next_state = S_PLLRST;
            end
            S_STABILIZE: begin
                if (!locked_s)               next_state = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST) next_state = S_HOLD;
            end
            S_HOLD: begin
                if (!locked_s)             next_state = S_WAIT_LOCK;
                else if (cnt == HOLD_LAST) next_state = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) next_state = S_WAIT_LOCK;
            end
            default: next_state = S_PLLRST;
        endcase
    end

    // Tick phase for the coming cycle: restarts at 0 on RUN entry
    always_comb begin
        next_phase = '0;
        if (next_state == S_RUN && state == S_RUN) begin
            next_phase = (tick_phase == TP_LAST) ? '0 : tick_phase + TP_W'(1);
        end
    end

    // State register and phase counter, counter cleared on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PLLRST;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered control outputs derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst    <= 1'b1;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            tick       <= 1'b0;
            tick_phase <= '0;
        end else begin
            pll_rst    <= (next_state == S_PLLRST);
            sys_rst_n  <= (next_state == S_RUN);
            ready      <= (next_state == S_RUN);
            tick_phase <= next_phase;
            tick       <= (next_state == S_RUN) && (next_phase == TP_LAST);
        end
    end

    // Count lock losses while running, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_count <= 8'd0;
        end else if (state == S_RUN && !locked_s && loss_count != 8'hFF) begin
            loss_count <= loss_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       tick;
    logic [1:0] tick_phase;
    logic [7:0] loss_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4),
        .TICK_DIV      (4),
        .CNT_W         (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .tick      (tick),
        .tick_phase(tick_phase),
        .loss_count(loss_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         adv;
        logic       lk;
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic       tk;
        logic [1:0] ph;
        logic [7:0] loss;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic prst,
                           input logic srst, input logic rdy, input logic tk,
                           input logic [1:0] ph, input logic [7:0] loss);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(prst));
        chk({tag, ".sys_rst_n"}, 32'(sys_rst_n), 32'(srst));
        chk({tag, ".ready"}, 32'(ready), 32'(rdy));
        chk({tag, ".tick"}, 32'(tick), 32'(tk));
        chk({tag, ".tick_phase"}, 32'(tick_phase), 32'(ph));
        chk({tag, ".loss_count"}, 32'(loss_count), 32'(loss));
    endtask

    // Advance n rising edges, then park on the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         exp_loss;
        logic       prev_tick;
        int         guard;
        logic [1:0] exp_ph;

        // lock-up, first ticks, first loss
        vecs[0]  = '{3,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[1]  = '{1,  1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[2]  = '{10, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[3]  = '{2,  1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[4]  = '{1,  1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[5]  = '{8,  1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[6]  = '{3,  1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[7]  = '{1,  1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0};
        vecs[8]  = '{1,  1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0};
        vecs[9]  = '{1,  1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd0};
        vecs[10] = '{1,  1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'd0};
        vecs[11] = '{1,  1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0};
        vecs[12] = '{2,  1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd0};
        vecs[13] = '{1,  1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};

        rst_n = 1'b0;
        pll_locked = 1'b0;
        step(2);
        chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            pll_locked = vecs[i].lk;
            step(vecs[i].adv);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].srst,
                    vecs[i].rdy, vecs[i].tk, vecs[i].ph, vecs[i].loss);
        end

        // one-cycle lock glitch 5 cycles into STABILIZE restarts qualification
        pll_locked = 1'b1;
        step(3);
        chk("glitch.enter_stab", 32'(state), 32'd2);
        step(5);
        chk("glitch.still_stab", 32'(state), 32'd2);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("glitch.back_wait", 32'(state), 32'd1);
        chk("glitch.sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("glitch.loss_count", 32'(loss_count), 32'd1);
        step(1);
        chk("glitch.restab", 32'(state), 32'd2);
        step(7);
        chk("glitch.stab_full", 32'(state), 32'd2);
        step(1);
        chk("glitch.hold", 32'(state), 32'd3);
        chk("glitch.hold_srst", 32'(sys_rst_n), 32'd0);
        step(3);
        chk("glitch.hold_end", 32'(state), 32'd3);
        step(1);
        chk("glitch.run", 32'(state), 32'd4);
        chk("glitch.run_srst", 32'(sys_rst_n), 32'd1);
        chk("glitch.run_phase", 32'(tick_phase), 32'd0);

        // tick cadence in RUN
        prev_tick = tick;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            exp_ph = 2'(i % 4);
            chk($sformatf("tick.phase%0d", i), 32'(tick_phase), 32'(exp_ph));
            chk($sformatf("tick.strobe%0d", i), 32'(tick), 32'(exp_ph == 2'd3));
            chk($sformatf("tick.adjacent%0d", i), 32'(tick && prev_tick), 32'd0);
            prev_tick = tick;
        end

        // repeated lock loss, loss_count saturates
        exp_loss = 1;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(2);
            chk($sformatf("loss%0d.pre", i), 32'(sys_rst_n), 32'd1);
            step(1);
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            chk($sformatf("loss%0d.state", i), 32'(state), 32'd1);
            chk($sformatf("loss%0d.srst", i), 32'(sys_rst_n), 32'd0);
            chk($sformatf("loss%0d.ready", i), 32'(ready), 32'd0);
            chk($sformatf("loss%0d.phase", i), 32'(tick_phase), 32'd0);
            chk($sformatf("loss%0d.count", i), 32'(loss_count), 32'(exp_loss));
            pll_locked = 1'b1;
            step(15);
            chk($sformatf("loss%0d.relock", i), 32'(sys_rst_n), 32'd1);
        end
        chk("loss.saturated", 32'(loss_count), 32'd255);

        // no lock: PLL reset pulses 4 high every 36 cycles
        pll_locked = 1'b0;
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            step(1);
            chk($sformatf("nolock.pll_rst%0d", k), 32'(pll_rst), 32'((k % 36) < 4));
            chk($sformatf("nolock.srst%0d", k), 32'(sys_rst_n), 32'd0);
        end

        // lock arriving on the timeout cycle wins over re-reset
        do_reset();
        step(33);
        pll_locked = 1'b1;
        step(2);
        chk("tmo.last_wait", 32'(state), 32'd1);
        chk("tmo.last_prst", 32'(pll_rst), 32'd0);
        step(1);
        chk("tmo.lock_wins", 32'(state), 32'd2);
        chk("tmo.no_prst", 32'(pll_rst), 32'd0);

        // asynchronous reset between edges while in HOLD
        guard = 0;
        while (state !== 3'd3 && guard < 100) begin
            step(1);
            guard++;
        end
        chk("async.reach_hold", 32'(state), 32'd3);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        rst_n = 1'b1;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
